// File: rtl/gerador_eco_pkg.sv
// Shared definitions for the ultrasonic echo emulator: state codes, default
// timing parameters and the distance validity test.
package gerador_eco_pkg;

    localparam int R_PADRAO        = 10;
    localparam int TRIG_MIN_PADRAO = 500;
    localparam int ATRASO_PADRAO   = 1000;

    typedef enum logic [3:0] {
        ST_INICIAL = 4'd0,
        ST_ESPERA  = 4'd1,
        ST_ATRASO  = 4'd2,
        ST_ECO     = 4'd3,
        ST_FIM     = 4'd4,
        ST_ERRO    = 4'd5
    } estado_t;

    // A distance is rejected if any digit is not BCD or the distance is zero.
    function automatic logic bcd_invalido(input logic [3:0] d2,
                                          input logic [3:0] d1,
                                          input logic [3:0] d0);
        return (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9) ||
               ({d2, d1, d0} == 12'h000);
    endfunction

endpackage

// File: rtl/contador_bcd_3digitos_dec.sv
// Loadable three-digit BCD down counter with borrow; holds at 000.
module contador_bcd_3digitos_dec
    import gerador_eco_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic       decrementa,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic [3:0] q2,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic       zero
);

    logic [11:0] carga;
    logic [11:0] valor;
    logic [2:0]  emprestimo;

    assign carga         = {d2, d1, d0};
    assign zero          = (valor == 12'h000);
    assign emprestimo[0] = decrementa & ~zero;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digito
            logic [3:0] dig_q;

            // A digit at 0 that is decremented wraps to 9 and borrows upward.
            if (gi < 2) begin : g_borrow
                assign emprestimo[gi+1] = emprestimo[gi] & (dig_q == 4'd0);
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    dig_q <= 4'd0;
                end else if (carrega) begin
                    dig_q <= carga[gi*4 +: 4];
                end else if (emprestimo[gi]) begin
                    dig_q <= (dig_q == 4'd0) ? 4'd9 : dig_q - 4'd1;
                end
            end

            assign valor[gi*4 +: 4] = dig_q;
        end
    endgenerate

    assign q2 = valor[11:8];
    assign q1 = valor[7:4];
    assign q0 = valor[3:0];

endmodule

// File: rtl/gerador_eco.sv
// Ultrasonic sensor emulator: after a valid trigger pulse, waits ATRASO clocks
// and then produces an echo pulse D*R clocks wide for the latched BCD distance.
module gerador_eco
    import gerador_eco_pkg::*;
#(
    parameter int R        = R_PADRAO,
    parameter int N        = 4,
    parameter int TRIG_MIN = TRIG_MIN_PADRAO,
    parameter int ATRASO   = ATRASO_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [3:0] digito2,
    input  logic [3:0] digito1,
    input  logic [3:0] digito0,
    output logic       echo,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int TW = $clog2(TRIG_MIN + 1);
    localparam int AW = $clog2(ATRASO + 1);

    estado_t       estado_q;
    logic [TW-1:0] trig_cnt_q;
    logic [AW-1:0] atr_cnt_q;
    logic [N-1:0]  tick_q;
    logic          echo_q;
    logic          pronto_q;
    logic          erro_q;

    logic          carrega;
    logic          tick_fim;
    logic          dec;
    logic          ultimo;
    logic          zero;
    logic [3:0]    q2, q1, q0;

    // The count saturates at TRIG_MIN, so equality means "wide enough".
    assign carrega  = (estado_q == ST_ESPERA) && !trigger &&
                      (trig_cnt_q == TW'(TRIG_MIN));
    assign tick_fim = (tick_q == N'(R - 1));
    assign dec      = (estado_q == ST_ECO) && tick_fim;
    assign ultimo   = ({q2, q1, q0} == 12'h001);

    contador_bcd_3digitos_dec u_contador (
        .clock      (clock),
        .reset      (reset),
        .carrega    (carrega),
        .decrementa (dec),
        .d2         (digito2),
        .d1         (digito1),
        .d0         (digito0),
        .q2         (q2),
        .q1         (q1),
        .q0         (q0),
        .zero       (zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= ST_INICIAL;
            trig_cnt_q <= '0;
            atr_cnt_q  <= '0;
            tick_q     <= '0;
            echo_q     <= 1'b0;
            erro_q     <= 1'b0;
            pronto_q   <= 1'b1;
        end else begin
            echo_q   <= 1'b0;
            erro_q   <= 1'b0;
            pronto_q <= 1'b0;
            case (estado_q)
                ST_INICIAL: begin
                    trig_cnt_q <= '0;
                    estado_q   <= ST_ESPERA;
                    pronto_q   <= 1'b1;
                end
                ST_ESPERA: begin
                    pronto_q <= !carrega;
                    if (trigger) begin
                        if (trig_cnt_q < TW'(TRIG_MIN))
                            trig_cnt_q <= trig_cnt_q + TW'(1);
                    end else begin
                        trig_cnt_q <= '0;
                        if (carrega) begin
                            atr_cnt_q <= '0;
                            if (bcd_invalido(digito2, digito1, digito0)) begin
                                estado_q <= ST_ERRO;
                                erro_q   <= 1'b1;
                            end else begin
                                estado_q <= ST_ATRASO;
                            end
                        end
                    end
                end
                ST_ATRASO: begin
                    if (atr_cnt_q == AW'(ATRASO - 1)) begin
                        estado_q <= ST_ECO;
                        echo_q   <= 1'b1;
                        tick_q   <= '0;
                    end else begin
                        atr_cnt_q <= atr_cnt_q + AW'(1);
                    end
                end
                ST_ECO: begin
                    // One BCD decrement per R clocks; the tick reaching 000 ends the pulse.
                    if (tick_fim) begin
                        tick_q <= '0;
                        if (ultimo || zero)
                            estado_q <= ST_FIM;
                        else
                            echo_q <= 1'b1;
                    end else begin
                        tick_q <= tick_q + N'(1);
                        echo_q <= 1'b1;
                    end
                end
                ST_FIM, ST_ERRO: begin
                    estado_q <= ST_INICIAL;
                    pronto_q <= 1'b1;
                end
                default: begin
                    estado_q <= ST_INICIAL;
                    pronto_q <= 1'b1;
                end
            endcase
        end
    end

    assign echo      = echo_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_gerador_eco.sv
// Self-checking bench for gerador_eco with R=10, TRIG_MIN=5, ATRASO=8.
module tb_gerador_eco;

    localparam int R        = 10;
    localparam int TRIG_MIN = 5;
    localparam int ATRASO   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       trigger = 1'b0;
    logic [3:0] digito2 = 4'd0, digito1 = 4'd0, digito0 = 4'd0;
    logic       echo, pronto, erro;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int rise;
        int width;
        int nrise;
        int nerro;
        int fim;
        int est1;
        bit done;
    } obs_t;

    gerador_eco #(.R(R), .N(4), .TRIG_MIN(TRIG_MIN), .ATRASO(ATRASO)) dut (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger),
        .digito2   (digito2),
        .digito1   (digito1),
        .digito0   (digito0),
        .echo      (echo),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Holds the digits and raises trigger for w rising edges, then drops it.
    task automatic pulso(input int w, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        repeat (2) @(negedge clock);
        digito2 = a; digito1 = b; digito0 = c;
        trigger = 1'b1;
        repeat (w) @(negedge clock);
        trigger = 1'b0;
    endtask

    // Observes the outputs cycle by cycle (cycle 1 = first edge after trigger fall).
    task automatic observar(input int janela, input bit perturb, output obs_t o);
        bit prev = 1'b0;
        bit caiu = 1'b0;
        o.rise = -1; o.width = 0; o.nrise = 0; o.nerro = 0; o.fim = -1; o.est1 = -1; o.done = 1'b0;
        for (int i = 1; i <= janela && !o.done; i++) begin
            @(posedge clock); #1;
            if (i == 1) o.est1 = int'(db_estado);
            if (echo && !prev) begin
                o.nrise++;
                if (o.rise < 0) o.rise = i;
            end
            if (echo) o.width++;
            if (erro) o.nerro++;
            if (!pronto) caiu = 1'b1;
            else if (caiu) begin o.done = 1'b1; o.fim = i; end
            prev = echo;
            if (perturb && (db_estado == 4'd2 || db_estado == 4'd3)) begin
                trigger = 1'($urandom);
                digito2 = 4'($urandom); digito1 = 4'($urandom); digito0 = 4'($urandom);
            end else begin
                trigger = 1'b0;
            end
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (echo !== 1'b0)     begin errors++; $display("FAIL reset_echo got=%b want=0", echo); end
        checks++; if (erro !== 1'b0)     begin errors++; $display("FAIL reset_erro got=%b want=0", erro); end
        checks++; if (pronto !== 1'b1)   begin errors++; $display("FAIL reset_pronto got=%b want=1", pronto); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got=%0d want=0", db_estado); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL reset_espera got=%0d want=1", db_estado); end
        checks++; if (pronto !== 1'b1)   begin errors++; $display("FAIL reset_pronto2 got=%b want=1", pronto); end
        $display("test_reset: done");
    endtask

    // Model: checks one measurement against the distance rules.
    task automatic medir_e_checar(input string nome, input int w, input logic [3:0] a,
                                  input logic [3:0] b, input logic [3:0] c, input bit perturb);
        obs_t o;
        int d = int'(a) * 100 + int'(b) * 10 + int'(c);
        bit valido = (w >= TRIG_MIN);
        bit ruim = (a > 9) || (b > 9) || (c > 9) || (d == 0);
        int janela = valido ? (ATRASO + d * R + 20) : 40;
        pulso(w, a, b, c);
        observar(janela, perturb, o);
        $display("%s: w=%0d D=%h%h%h rise=%0d width=%0d erro=%0d fim=%0d", nome, w, a, b, c, o.rise, o.width, o.nerro, o.fim);
        if (!valido) begin
            checks++; if (o.done !== 1'b0) begin errors++; $display("FAIL %s_pronto_drop got=%b want=0", nome, o.done); end
            checks++; if (o.width != 0)    begin errors++; $display("FAIL %s_echo got=%0d want=0", nome, o.width); end
            checks++; if (o.nerro != 0)    begin errors++; $display("FAIL %s_erro got=%0d want=0", nome, o.nerro); end
            checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL %s_pronto got=%b want=1", nome, pronto); end
        end else if (ruim) begin
            checks++; if (o.est1 != 5)  begin errors++; $display("FAIL %s_estado got=%0d want=5", nome, o.est1); end
            checks++; if (o.nerro != 1) begin errors++; $display("FAIL %s_erro got=%0d want=1", nome, o.nerro); end
            checks++; if (o.width != 0) begin errors++; $display("FAIL %s_echo got=%0d want=0", nome, o.width); end
            checks++; if (!o.done || o.fim != 2) begin errors++; $display("FAIL %s_fim got=%0d want=2", nome, o.fim); end
        end else begin
            checks++; if (o.est1 != 2)          begin errors++; $display("FAIL %s_estado got=%0d want=2", nome, o.est1); end
            checks++; if (o.rise != ATRASO + 1) begin errors++; $display("FAIL %s_rise got=%0d want=%0d", nome, o.rise, ATRASO + 1); end
            checks++; if (o.width != d * R)     begin errors++; $display("FAIL %s_width got=%0d want=%0d", nome, o.width, d * R); end
            checks++; if (o.nrise != 1)         begin errors++; $display("FAIL %s_pulses got=%0d want=1", nome, o.nrise); end
            checks++; if (o.nerro != 0)         begin errors++; $display("FAIL %s_erro got=%0d want=0", nome, o.nerro); end
            checks++; if (!o.done || o.fim != ATRASO + d * R + 2)
                begin errors++; $display("FAIL %s_fim got=%0d want=%0d", nome, o.fim, ATRASO + d * R + 2); end
        end
    endtask

    task automatic test_valido;           medir_e_checar("test_valido", 5, 4'd0, 4'd1, 4'd2, 1'b0); endtask
    task automatic test_trigger_curto;    medir_e_checar("test_trigger_curto", 4, 4'd0, 4'd5, 4'd0, 1'b0); endtask
    task automatic test_distancia_zero;   medir_e_checar("test_distancia_zero", 5, 4'd0, 4'd0, 4'd0, 1'b0); endtask
    task automatic test_digito_invalido;  medir_e_checar("test_digito_invalido", 5, 4'd0, 4'hA, 4'd3, 1'b0); endtask
    task automatic test_max_perturbado;   medir_e_checar("test_max_perturbado", 6, 4'd9, 4'd9, 4'd9, 1'b1); endtask

    task automatic test_reset_eco;
        int n = 0;
        int vistos = 0;
        pulso(5, 4'd1, 4'd0, 4'd0);
        while (!echo && n < 50) begin @(posedge clock); #1; n++; end
        checks++; if (echo !== 1'b1) begin errors++; $display("FAIL reset_eco_timeout got=%b want=1", echo); end
        if (echo) vistos = 1;
        while (vistos < 50 && n < 1200) begin
            @(posedge clock); #1; n++;
            if (echo) vistos++;
        end
        checks++; if (vistos != 50) begin errors++; $display("FAIL reset_eco_count got=%0d want=50", vistos); end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (echo !== 1'b0)      begin errors++; $display("FAIL reset_eco_echo got=%b want=0", echo); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_eco_estado got=%0d want=0", db_estado); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL reset_eco_pronto got=%b want=1", pronto); end
        n = 0;
        for (int i = 0; i < 1200; i++) begin @(posedge clock); #1; if (echo) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL reset_eco_residual got=%0d want=0", n); end
        $display("test_reset_eco: echo cycles before reset=%0d residual=%0d", vistos, n);
    endtask

    task automatic test_aleatorio;
        for (int t = 0; t < 10; t++) begin
            int w = $urandom_range(7, 1);
            logic [3:0] a = 4'($urandom_range(1, 0));
            logic [3:0] b = 4'($urandom_range(11, 0));
            logic [3:0] c = 4'($urandom_range(11, 0));
            medir_e_checar("test_aleatorio", w, a, b, c, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_valido();
        test_trigger_curto();
        test_distancia_zero();
        test_digito_invalido();
        test_reset_eco();
        test_max_perturbado();
        test_aleatorio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gerador_eco.md
GERADOR_ECO -- requirements
Module: gerador_eco

Interface
REQ-001 SHALL have parameter R, default 10, meaning clocks per cm of emulated distance.
REQ-002 SHALL have parameter N, default 4, meaning tick counter width, ceil(log2(R)).
REQ-003 SHALL have parameter TRIG_MIN, default 500, meaning minimum valid trigger width in clocks (10 us at 50 MHz).
REQ-004 SHALL have parameter ATRASO, default 1000, meaning clocks from accepted trigger to echo rise (burst emulation).
REQ-005 SHALL have port clock, input, 1, meaning system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-low reset; the block's only clock is clock.
REQ-007 SHALL have port trigger, input, 1, meaning sensor trigger request, level, synchronous to clock.
REQ-008 SHALL have ports digito2, digito1, digito0, input, 4 each, meaning BCD distance in cm (hundreds, tens, units).
REQ-009 SHALL have port echo, output, 1, meaning emulated sensor echo pulse, registered.
REQ-010 SHALL have port pronto, output, 1, meaning block idle and able to accept a trigger.
REQ-011 SHALL have port erro, output, 1, meaning one-cycle flag for a rejected measurement.
REQ-012 SHALL have port db_estado, output, 4, meaning current FSM state code.

Function
REQ-013 SHALL implement FSM states INICIAL, ESPERA, ATRASO, ECO, FIM, ERRO.
REQ-014 SHALL, in INICIAL, assert pronto, clear the trigger width counter, and go to ESPERA on the next cycle.
REQ-015 SHALL, in ESPERA, keep pronto=1 and count consecutive trigger-high cycles, saturating at TRIG_MIN.
REQ-016 SHALL, on the first cycle trigger is low after being high with count>=TRIG_MIN, latch digito2..0 and leave ESPERA.
REQ-017 SHALL, on a trigger fall with count<TRIG_MIN, discard the pulse, clear the count and stay in ESPERA.
REQ-018 SHALL go to ERRO instead of ATRASO if any latched digit is >9 or the latched distance is 000.
REQ-019 SHALL, in ERRO, assert erro for exactly one cycle with echo=0, then return to INICIAL.
REQ-020 SHALL, in ATRASO, hold echo=0 for exactly ATRASO cycles, then enter ECO.
REQ-021 SHALL, in ECO, drive echo=1 for exactly D*R consecutive cycles, where D is the latched distance in cm.
REQ-022 SHALL obtain the ECO width by decrementing the latched BCD value once per R-cycle tick and leaving ECO when the tick that reaches 000 occurs.
REQ-023 SHALL perform BCD decrement with borrow (x0 -> x9 with borrow to the next digit); the count never wraps below 000.
REQ-024 SHALL, in FIM, drive echo=0 for one cycle, then go to INICIAL.
REQ-025 SHALL ignore trigger and digito inputs outside ESPERA; changes to them during ATRASO/ECO SHALL NOT affect the pulse.
REQ-026 SHALL deassert pronto in ATRASO, ECO, FIM and ERRO.
REQ-027 SHALL support a maximum D=999 (echo width 999*R clocks) without overflow.

Reset
REQ-028 SHALL, while reset=0 at a rising edge, enter INICIAL, force echo=0 and erro=0, clear all counters and latched BCD; pronto=1 from the next cycle.
REQ-029 SHALL, on reset mid-ATRASO or mid-ECO, drop echo at the same edge and produce no residual pulse.

Structure
REQ-030 SHALL place state encodings and default values for R, TRIG_MIN and ATRASO in a shared package gerador_eco_pkg.
REQ-031 SHALL use one sub-module, contador_bcd_3digitos_dec, a loadable 3-digit BCD down counter with a zero flag; tick generation reuses the existing modulo-M counter.

Verification (R=10, TRIG_MIN=5, ATRASO=8)
REQ-032 SHALL check: trigger high 5 cycles, D=012 -> echo rises 8 cycles after ATRASO entry, stays high exactly 120 cycles, pronto returns to 1.
REQ-033 SHALL check: trigger high 4 cycles, D=050 -> no echo, no erro, pronto stays 1.
REQ-034 SHALL check: valid trigger, D=000 -> erro high exactly 1 cycle, echo never rises.
REQ-035 SHALL check: valid trigger, digito1=4'hA -> erro 1 cycle, no echo.
REQ-036 SHALL check: D=100, reset low at echo cycle 50 -> echo=0 at that edge, state INICIAL, pronto=1 next cycle.
REQ-037 SHALL check: D=999 with extra trigger pulses and digit changes during ECO -> echo width exactly 9990 cycles, unaffected.
